des_block_packer: RTL

- Upstream feeder for the combinational DES core: turns a byte stream into 64-bit `plaintext` blocks and holds `primaryKey` in a register.
- Holds each block stable on its outputs until the downstream stage accepts it. This gives the DES core a full cycle of stable inputs.
- Pads the final partial block using PKCS#5, or zero-fills it, depending on a parameter.

---
 rtl/des_block_packer.sv | 109 ++++++++++
 1 files changed

// File: rtl/des_block_packer.sv
// rtl/des_block_packer.sv - byte-stream to 64-bit DES block packer with key register
// Blocks are held stable on plaintext/primaryKey until the downstream handshake completes.
module des_block_packer #(
  parameter bit PAD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             keyLoad,
  input  logic [1:64]      keyIn,
  input  logic [7:0]       byteIn,
  input  logic             byteValid,
  input  logic             byteLast,
  output logic             byteReady,
  output logic [1:64]      plaintext,
  output logic [1:64]      primaryKey,
  output logic             blockValid,
  input  logic             blockReady,
  output logic             blockLast,
  output logic [CNT_W-1:0] blockCount
);

  typedef enum logic [1:0] {S_FILL, S_PAD, S_HOLD, S_PADBLK} state_t;

  state_t           r_state;
  logic [2:0]       r_idx;
  logic             r_pad_flag;
  logic [1:64]      r_plaintext;
  logic [1:64]      r_key;
  logic             r_valid;
  logic             r_last;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       w_pad_byte;

  // Bytes r_idx..7 remain to be filled, so PKCS#5 pad value is their count.
  assign w_pad_byte = PAD_EN ? (8'd8 - {5'd0, r_idx}) : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FILL;
      r_idx       <= 3'd0;
      r_pad_flag  <= 1'b0;
      r_plaintext <= '0;
      r_key       <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_count     <= '0;
    end else begin
      if (keyLoad && (r_state != S_HOLD)) r_key <= keyIn;
      case (r_state)
        S_FILL: begin
          if (byteValid) begin
            for (int b = 0; b < 8; b++) begin
              if (3'(b) == r_idx) r_plaintext[8*b+1 +: 8] <= byteIn;
            end
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= S_HOLD;
              r_valid <= 1'b1;
              if (byteLast) begin
                r_last     <= ~PAD_EN;
                r_pad_flag <= PAD_EN;
              end
            end else if (byteLast) begin
              r_state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          for (int b = 0; b < 8; b++) begin
            if (3'(b) >= r_idx) r_plaintext[8*b+1 +: 8] <= w_pad_byte;
          end
          r_idx   <= 3'd0;
          r_state <= S_HOLD;
          r_valid <= 1'b1;
          r_last  <= 1'b1;
        end
        S_HOLD: begin
          if (r_valid && blockReady) begin
            r_valid <= 1'b0;
            r_count <= r_count + CNT_W'(1);
            if (r_pad_flag) begin
              r_state <= S_PADBLK;
            end else begin
              r_state <= S_FILL;
              r_last  <= 1'b0;
            end
          end
        end
        S_PADBLK: begin
          r_plaintext <= 64'h0808080808080808;
          r_last      <= 1'b1;
          r_pad_flag  <= 1'b0;
          r_state     <= S_HOLD;
          r_valid     <= 1'b1;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign byteReady  = (r_state == S_FILL);
  assign plaintext  = r_plaintext;
  assign primaryKey = r_key;
  assign blockValid = r_valid;
  assign blockLast  = r_last;
  assign blockCount = r_count;

endmodule
